// File: rtl/mpu_pkg.sv
// Shared definitions for the MPU determinant engine: defaults, FSM states and
// width/index helpers.
package mpu_pkg;

    localparam int MAX_N_DEF  = 5;
    localparam int ELEM_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE, LOAD, MUL, ACC, NEXT, DONE
    } det_state_t;

    // Worst-case term magnitude plus growth from summing max_n! terms, plus sign.
    function automatic int acc_width(input int elem_w, input int max_n);
        int f;
        f = 1;
        for (int k = 2; k <= max_n; k++) f = f * k;
        return elem_w * max_n + $clog2(f) + 1;
    endfunction

    function automatic int elem_idx(input int r, input int c, input int max_n);
        return r * max_n + c;
    endfunction

endpackage

// File: rtl/mpu_det_seq_if.sv
// Request/response bundle of the determinant engine. The ovf output exists
// only when MPU_DET_SAT_EN is defined.
interface mpu_det_seq_if #(
    parameter int ELEM_W = 8,
    parameter int MAX_N  = 5,
    parameter int DET_W  = 48
);
    localparam int SIZE_W = $clog2(MAX_N + 1);

    logic                          start;
    logic [SIZE_W-1:0]             size;
    logic [MAX_N*MAX_N*ELEM_W-1:0] matrix;
    logic                          busy;
    logic                          done;
    logic                          err;
    logic [DET_W-1:0]              det;
`ifdef MPU_DET_SAT_EN
    logic                          ovf;
`endif

    modport slave (
        input  start, size, matrix,
`ifdef MPU_DET_SAT_EN
        output ovf,
`endif
        output busy, done, err, det
    );

    modport master (
        output start, size, matrix,
`ifdef MPU_DET_SAT_EN
        input  ovf,
`endif
        input  busy, done, err, det
    );

endinterface

// File: rtl/mpu_perm_gen.sv
// Iterative Heap's-algorithm permutation generator; one step per step_i pulse,
// each swap flips the permutation parity.
module mpu_perm_gen #(
    parameter int MAX_N = 5,
    parameter int IDX_W = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [IDX_W-1:0]            n_i,
    input  logic                        init_i,
    input  logic                        step_i,
    output logic [MAX_N-1:0][IDX_W-1:0] perm_o,
    output logic                        sign_o,
    output logic                        last_o,
    output logic                        swap_o
);

    logic [MAX_N-1:0][IDX_W-1:0] perm_q, perm_d, c_q, c_d;
    logic [IDX_W-1:0]            i_q, i_d, j;
    logic                        sign_q, sign_d;

    assign last_o = (i_q == n_i);
    assign swap_o = !last_o && (c_q[i_q] < i_q);
    assign j      = i_q[0] ? c_q[i_q] : '0;
    assign perm_o = perm_q;
    assign sign_o = sign_q;

    always_comb begin
        perm_d = perm_q;
        c_d    = c_q;
        i_d    = i_q;
        sign_d = sign_q;
        if (init_i) begin
            for (int k = 0; k < MAX_N; k++) perm_d[k] = IDX_W'(k);
            c_d    = '0;
            i_d    = IDX_W'(1);
            sign_d = 1'b0;
        end else if (step_i) begin
            if (swap_o) begin
                perm_d[i_q] = perm_q[j];
                perm_d[j]   = perm_q[i_q];
                sign_d      = ~sign_q;
                c_d[i_q]    = c_q[i_q] + 1'b1;
                i_d         = IDX_W'(1);
            end else begin
                c_d[i_q] = '0;
                i_d      = i_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm_q <= '0;
            c_q    <= '0;
            i_q    <= '0;
            sign_q <= 1'b0;
        end else begin
            perm_q <= perm_d;
            c_q    <= c_d;
            i_q    <= i_d;
            sign_q <= sign_d;
        end
    end

endmodule

// File: rtl/mpu_det_seq.sv
// Sequential Leibniz-expansion determinant engine, one MAC per cycle.
// Define MPU_DET_SAT_EN for a saturating det with an ovf flag.
module mpu_det_seq
    import mpu_pkg::*;
#(
    parameter int ELEM_W = ELEM_W_DEF,
    parameter int MAX_N  = MAX_N_DEF,
    parameter int DET_W  = 48
) (
    input  logic          clk,
    input  logic          rst_n,
    mpu_det_seq_if.slave  bus
);

    localparam int SIZE_W = $clog2(MAX_N + 1);
    localparam int ACC_W  = acc_width(ELEM_W, MAX_N);
    localparam logic signed [ACC_W-1:0] ONE = ACC_W'(1);

    det_state_t                    state_q, state_d;
    logic [SIZE_W-1:0]             n_q, n_d, r_q, r_d;
    logic [MAX_N*MAX_N*ELEM_W-1:0] mat_q, mat_d;
    logic signed [ACC_W-1:0]       prod_q, prod_d, acc_q, acc_d;
    logic signed [ACC_W-1:0]       acc_sum, acc_nxt, a_ext;
    logic [DET_W-1:0]              det_q, det_d;
    logic signed [DET_W-1:0]       det_wrap, det_fin;
    logic                          err_q, err_d;
    logic signed [ELEM_W-1:0]      elem [MAX_N][MAX_N];
    logic signed [ELEM_W-1:0]      a_sel;

    logic                          pg_init, pg_step, pg_sign, pg_last, pg_swap;
    logic [MAX_N-1:0][SIZE_W-1:0]  pg_perm;

    mpu_perm_gen #(.MAX_N(MAX_N), .IDX_W(SIZE_W)) u_perm (
        .clk    (clk),
        .rst_n  (rst_n),
        .n_i    (n_q),
        .init_i (pg_init),
        .step_i (pg_step),
        .perm_o (pg_perm),
        .sign_o (pg_sign),
        .last_o (pg_last),
        .swap_o (pg_swap)
    );

    for (genvar gr = 0; gr < MAX_N; gr++) begin : g_row
        for (genvar gc = 0; gc < MAX_N; gc++) begin : g_col
            assign elem[gr][gc] = mat_q[elem_idx(gr, gc, MAX_N)*ELEM_W +: ELEM_W];
        end
    end

    assign a_sel    = elem[r_q][pg_perm[r_q]];
    assign a_ext    = ACC_W'(a_sel);
    assign acc_sum  = pg_sign ? (acc_q - prod_q) : (acc_q + prod_q);
    assign acc_nxt  = (state_q == ACC) ? acc_sum : acc_q;
    assign det_wrap = DET_W'(acc_nxt);

`ifdef MPU_DET_SAT_EN
    localparam logic [DET_W-1:0] DMAX = {1'b0, {(DET_W-1){1'b1}}};
    localparam logic [DET_W-1:0] DMIN = {1'b1, {(DET_W-1){1'b0}}};
    logic fits;
    logic ovf_q, ovf_d;
    assign fits    = (ACC_W'(det_wrap) == acc_nxt);
    assign det_fin = fits ? det_wrap : (acc_nxt[ACC_W-1] ? DMIN : DMAX);
    assign bus.ovf = ovf_q;
`else
    assign det_fin = det_wrap;
`endif

    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        r_d     = r_q;
        mat_d   = mat_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        det_d   = det_q;
        err_d   = err_q;
        pg_init = 1'b0;
        pg_step = 1'b0;
`ifdef MPU_DET_SAT_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: if (bus.start) begin
                mat_d = bus.matrix;
                n_d   = bus.size;
                det_d = '0;
`ifdef MPU_DET_SAT_EN
                ovf_d = 1'b0;
`endif
                if (bus.size == '0 || bus.size > SIZE_W'(MAX_N)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    err_d   = 1'b0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                pg_init = 1'b1;
                prod_d  = ONE;
                acc_d   = '0;
                r_d     = '0;
                state_d = MUL;
            end
            MUL: begin
                prod_d = prod_q * a_ext;
                r_d    = r_q + 1'b1;
                if (r_q == n_q - 1'b1) state_d = ACC;
            end
            ACC: begin
                acc_d   = acc_sum;
                prod_d  = ONE;
                r_d     = '0;
                state_d = NEXT;
                // A 1x1 expansion has a single term: finish without a NEXT visit.
                if (pg_last) begin
                    det_d   = det_fin;
                    state_d = DONE;
`ifdef MPU_DET_SAT_EN
                    ovf_d   = ~fits;
`endif
                end
            end
            NEXT: begin
                if (pg_last) begin
                    det_d   = det_fin;
                    state_d = DONE;
`ifdef MPU_DET_SAT_EN
                    ovf_d   = ~fits;
`endif
                end else begin
                    pg_step = 1'b1;
                    if (pg_swap) state_d = MUL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            n_q     <= '0;
            r_q     <= '0;
            mat_q   <= '0;
            prod_q  <= '0;
            acc_q   <= '0;
            det_q   <= '0;
            err_q   <= 1'b0;
`ifdef MPU_DET_SAT_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            r_q     <= r_d;
            mat_q   <= mat_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            det_q   <= det_d;
            err_q   <= err_d;
`ifdef MPU_DET_SAT_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign bus.busy = (state_q inside {LOAD, MUL, ACC, NEXT});
    assign bus.done = (state_q == DONE);
    assign bus.err  = err_q;
    assign bus.det  = det_q;

endmodule

// File: tb/tb_mpu_det_seq.sv
// Directed scoreboard bench for mpu_det_seq; MPU_DET_SAT_EN selects a 32-bit
// saturating build.
module tb_mpu_det_seq;

`ifdef MPU_DET_SAT_EN
    localparam int DW = 32;
`else
    localparam int DW = 48;
`endif

    typedef struct {
        logic [DW-1:0] det;
        logic          err;
        logic          ovf;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst_n = 1'b0;
    int     checks = 0;
    int     errors = 0;
    exp_t   sbq[$];
    logic [199:0] m;

    always #5 clk = ~clk;

    mpu_det_seq_if #(.ELEM_W(8), .MAX_N(5), .DET_W(DW)) dif ();

    mpu_det_seq #(.ELEM_W(8), .MAX_N(5), .DET_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dif)
    );

    function automatic logic [DW-1:0] wdet(input longint v);
`ifdef MPU_DET_SAT_EN
        longint mx, mn;
        mx = (longint'(1) <<< (DW - 1)) - 1;
        mn = -mx - 1;
        if (v > mx) v = mx;
        if (v < mn) v = mn;
`endif
        return v[DW-1:0];
    endfunction

    function automatic logic wovf(input longint v);
`ifdef MPU_DET_SAT_EN
        longint mx;
        mx = (longint'(1) <<< (DW - 1)) - 1;
        return (v > mx) || (v < -mx - 1);
`else
        return (v != v);
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic set_el(input int r, input int c, input int v);
        m[(r*5+c)*8 +: 8] = 8'(v);
    endtask

    task automatic diag(input int v);
        m = '0;
        for (int k = 0; k < 5; k++) set_el(k, k, v);
    endtask

    // Issue one request, push its expectation, wait for done within a budget.
    task automatic run(input string name, input int n, input longint exp_v,
                       input bit exp_err, input int lat, input bit disturb);
        exp_t e;
        int   cyc;
        bit   got;
        e.det = exp_err ? '0 : wdet(exp_v);
        e.err = exp_err;
        e.ovf = exp_err ? 1'b0 : wovf(exp_v);
        @(posedge clk); #1;
        dif.start  = 1'b1;
        dif.size   = 3'(n);
        dif.matrix = m;
        sbq.push_back(e);
        @(posedge clk); #1;
        dif.start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1 && !exp_err) chk({name, "_busy"}, longint'(dif.busy), 1);
            if (disturb && cyc == 5) begin
                dif.start  = 1'b1;
                dif.size   = 3'd2;
                dif.matrix = ~m;
            end
            if (disturb && cyc == 6) dif.start = 1'b0;
            if (dif.done) got = 1'b1;
        end
        if (!got) chk({name, "_timeout"}, 0, 1);
        else if (lat > 0) chk({name, "_latency"}, longint'(cyc), longint'(lat));
    endtask

    always @(negedge clk) begin
        if (rst_n && dif.done) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done det=%0d err=%0b", $signed(dif.det), dif.err);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (dif.det !== e.det || dif.err !== e.err
`ifdef MPU_DET_SAT_EN
                    || dif.ovf !== e.ovf
`endif
                ) begin
                    errors++;
                    $display("FAIL result det=%0d err=%0b required det=%0d err=%0b ovf=%0b",
                             $signed(dif.det), dif.err, $signed(e.det), e.err, e.ovf);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        dif.start  = 1'b0;
        dif.size   = '0;
        dif.matrix = '0;
        m          = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", longint'(dif.busy), 0);
        chk("rst_done", longint'(dif.done), 0);
        chk("rst_err",  longint'(dif.err),  0);
        chk("rst_det",  longint'(dif.det),  0);
        rst_n = 1'b1;

        m = '0; set_el(0, 0, -7);
        run("n1", 1, -7, 1'b0, 4, 1'b0);

        m = '0;
        set_el(0, 0, 3); set_el(0, 1, 8);
        set_el(1, 0, 4); set_el(1, 1, 6);
        run("n2", 2, -14, 1'b0, 0, 1'b0);

        m = '0;
        set_el(0, 0, 6); set_el(0, 1, 1);  set_el(0, 2, 1);
        set_el(1, 0, 4); set_el(1, 1, -2); set_el(1, 2, 5);
        set_el(2, 0, 2); set_el(2, 1, 8);  set_el(2, 2, 7);
        run("n3", 3, -306, 1'b0, 0, 1'b0);

        m = '0;
        set_el(0, 0, 2); set_el(0, 3, 1); set_el(1, 1, 3);
        set_el(2, 2, 4); set_el(3, 0, 1); set_el(3, 3, 5);
        run("n4", 4, 108, 1'b0, 0, 1'b0);

        m = '0;
        for (int k = 0; k < 5; k++) set_el(k, 4 - k, -3);
        run("n5_anti", 5, -243, 1'b0, 0, 1'b0);

        diag(127);
        run("n5_p127", 5, 64'sd33038369407, 1'b0, 0, 1'b0);
        diag(-128);
        run("n5_m128", 5, -64'sd34359738368, 1'b0, 0, 1'b0);

        run("sz0", 0, 0, 1'b1, 1, 1'b0);
        run("sz6", 6, 0, 1'b1, 1, 1'b0);

        m = '0;
        set_el(0, 0, 3); set_el(0, 1, 8);
        set_el(1, 0, 4); set_el(1, 1, 6);
        run("err_clear", 2, -14, 1'b0, 0, 1'b0);

        m = '0;
        set_el(0, 0, 6); set_el(0, 1, 1);  set_el(0, 2, 1);
        set_el(1, 0, 4); set_el(1, 1, -2); set_el(1, 2, 5);
        set_el(2, 0, 2); set_el(2, 1, 8);  set_el(2, 2, 7);
        run("busy_ignore", 3, -306, 1'b0, 0, 1'b1);

        diag(127);
        @(posedge clk); #1;
        dif.start  = 1'b1;
        dif.size   = 3'd5;
        dif.matrix = m;
        @(posedge clk); #1;
        dif.start = 1'b0;
        repeat (50) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", longint'(dif.busy), 0);
        chk("abort_done", longint'(dif.done), 0);
        chk("abort_err",  longint'(dif.err),  0);
        chk("abort_det",  longint'(dif.det),  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("abort_idle", longint'(dif.busy), 0);

        diag(-128);
        run("after_abort", 5, -64'sd34359738368, 1'b0, 0, 1'b0);

        repeat (3) @(negedge clk);
        chk("sb_drained", longint'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
